muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised sequential multiply/divide unit. It computes signed or unsigned products and quotients/remainders of two `WIDTH`-bit operands over `WIDTH+2` cycles, using a start/busy/done handshake. It replaces the fixed 32-bit multiplier/divisor pair that feeds Hi/Lo in the multicycle CPU datapath. The control FSM holds its state until `done`, then loads Hi/Lo from `hi`/`lo`.

## Interface
- `WIDTH`, 32: operand width; must be ≥ 4 and even.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: reset, asynchronous assert, active-low.
- `start` input 1: request; sampled only while idle.
- `op` input 2: operation select.
  - 00 = mult (signed)
  - 01 = div (signed)
  - 10 = multu
  - 11 = divu
- `a` input WIDTH: multiplicand / dividend; captured on the accepted `start`.
- `b` input WIDTH: multiplier / divisor; captured on the accepted `start`.
- `busy` output 1: an operation is in progress.
- `done` output 1: one-cycle completion pulse.
- `divby0` output 1: one-cycle pulse coincident with `done` when a division had `b == 0`.
- `hi` output WIDTH: product high half, or remainder.
- `lo` output WIDTH: product low half, or quotient.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE or DONE, `start`=1:
  - capture `op`, `a` and `b`;
  - signed ops store operand magnitudes plus result-sign flags;
  - go to CALC with iteration counter = WIDTH-1.
- Division with `b == 0`: go straight to DONE with `divby0`=1; `hi`/`lo` are not updated.
- CALC, multiply: radix-2 shift-add; one multiplier bit per cycle over a 2·WIDTH accumulator.
- CALC, divide: restoring division; one quotient bit per cycle.
- Counter decrements every CALC cycle; at 0, go to FIX.
- FIX:
  - multiply: negate the 2·WIDTH product when operand signs differ;
  - divide: negate the quotient when signs differ; the remainder takes the sign of the dividend;
  - go to DONE.
- DONE:
  - registers `hi`/`lo`, pulses `done`;
  - returns to IDLE unless `start`=1, in which case the new operation is accepted (back-to-back).
- Arithmetic rules:
  - multiply: {hi,lo} = full 2·WIDTH product;
  - divide: quotient truncates toward zero;
  - signed MIN/−1: lo = MIN (wraps), hi = 0;
  - divu treats operands as unsigned; no overflow flag exists.
- `start` during CALC or FIX is ignored; no queuing.
- Illegal op values do not exist; all four encodings are defined.

## Timing
- Reset values: `busy`=0, `done`=0, `divby0`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Accepted `start` at edge 0:
  - `busy`=1 from edge 0 through edge WIDTH+1;
  - `done`, `hi` and `lo` become valid after edge WIDTH+2; `done` is high for exactly that one cycle, with `busy`=0.
- Divide-by-zero: `done` and `divby0` are high after edge 2; `busy`=1 only after edge 1.
- `hi`/`lo` hold their value until the next non-div-by-zero completion.
- Reset asserted mid-operation aborts immediately:
  - all outputs return to reset values;
  - no `done` follows.

## Configuration
- `MULDIV_UNSIGNED_EN` defined: multu/divu behave as above.
- Macro undefined:
  - `op[1]` is ignored and multu/divu execute as mult/div;
  - the unsigned-path muxing is removed.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encoding constants (OP_MULT, OP_DIV, OP_MULTU, OP_DIVU);
  - the FSM state typedef;
  - the default-width constant.
- One sub-module, `muldiv_signfix`: combinational conditional two's-complement negation, WIDTH-parameterised.
  - Instantiated for operand magnitude conversion.
  - Instantiated for FIX-stage result correction.

## Test plan
All scenarios use WIDTH=32.
- mult a=7, b=0xFFFFFFFD (−3) → after 34 cycles: `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=b=0xFFFFFFFF:
  - with `MULDIV_UNSIGNED_EN`: hi=0xFFFFFFFE, lo=0x00000001;
  - without it: hi=0, lo=1.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- div a=5, b=0 after a prior result hi=1/lo=2:
  - `done` and `divby0` high 2 cycles after start;
  - hi=1 and lo=2 are unchanged.
- `start` re-pulsed at cycle 5 of a mult is ignored (`done` still at cycle 34); reset asserted at cycle 10 of a div gives `busy`=0, hi=lo=0, and no `done`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// FSM state type and the default operand width.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_DIV   = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation. Converts signed operands to
// magnitudes on entry and restores result signs after the iterations.
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] out_o
);

   // negate when requested, pass through otherwise
   always_comb begin
      out_o = neg_i ? ((~in_i) + WIDTH'(1)) : in_i;
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign-fix stage.
// Optional feature macro: MULDIV_UNSIGNED_EN enables multu/divu; without it
// op[1] is ignored and every operation is signed.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             divby0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {product hi, multiplier} or {remainder, quotient}
   logic [WIDTH-1:0]   m_q, m_d;         // multiplicand or divisor magnitude
   logic               div_q, div_d;
   logic               neg_q, neg_d;     // product / quotient sign
   logic               rneg_q, rneg_d;   // remainder sign (dividend sign)
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               divby0_q, divby0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               op_div, op_signed, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign op_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_UNSIGNED_EN
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
`else
   assign op_signed = 1'b1;
`endif
   assign a_neg  = op_signed & a[WIDTH-1];
   assign b_neg  = op_signed & b[WIDTH-1];
   assign b_zero = (b == '0);

   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.in_i(a), .neg_i(a_neg), .out_o(a_mag));
   muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.in_i(b), .neg_i(b_neg), .out_o(b_mag));

   // One shift-add step: add multiplicand to the high half when the current
   // multiplier bit is set, then shift the whole accumulator right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring-divide step: shift the next dividend bit into the partial
   // remainder and subtract when it fits; bit WIDTH of the difference is the borrow.
   assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = div_tmp - {1'b0, m_q};
   assign div_next = div_diff[WIDTH]
                   ? {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.in_i(acc_q), .neg_i(neg_q), .out_o(prod_fix));
   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (.in_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .out_o(quo_fix));
   muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.in_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .out_o(rem_fix));

   // Next-state and datapath decisions; defaults hold every register.
   always_comb begin
      logic accept_dz;
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      m_d       = m_q;
      div_d     = div_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divby0_d  = 1'b0;
      accept_dz = 1'b0;

      case (state_q)
         ST_CALC: begin
            acc_d = div_q ? div_next : mul_next;
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIX: begin
            if (!dz_q) begin
               acc_d = div_q ? {rem_fix, quo_fix} : prod_fix;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d   = 1'b1;
            divby0_d = dz_q;
            if (!dz_q) begin
               hi_d = acc_q[2*WIDTH-1:WIDTH];
               lo_d = acc_q[WIDTH-1:0];
            end
            state_d = ST_IDLE;
         end
         default: ;
      endcase

      // New requests are taken while idle or in the completion cycle.
      if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
         div_d  = op_div;
         neg_d  = a_neg ^ b_neg;
         rneg_d = a_neg;
         cnt_d  = CW'(WIDTH - 1);
         if (op_div) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            m_d   = b_mag;
         end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            m_d   = a_mag;
         end
         if (op_div && b_zero) begin
            // Divide-by-zero passes through FIX untouched so that done lands
            // two edges after acceptance, with busy only in the DONE cycle.
            dz_d      = 1'b1;
            accept_dz = 1'b1;
            state_d   = ST_FIX;
         end else begin
            dz_d    = 1'b0;
            state_d = ST_CALC;
         end
      end

      busy_d = (state_d != ST_IDLE) && !accept_dz;
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         m_q      <= '0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         divby0_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         divby0_q <= divby0_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign divby0 = divby0_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq (WIDTH=32): directed operations with hand-computed
// results, plus an arithmetic/timeline reference model compared every cycle.
module tb_muldiv_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, divby0;
   logic [W-1:0]  hi, lo;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   muldiv_seq #(.WIDTH(W)) dut (
      .clock (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .divby0(divby0),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: returns {divide_by_zero, hi, lo}.
   function automatic logic [2*W:0] model_res(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      bit          sgn;
      longint      sx, sy, sq, sr;
      logic [63:0] ux, uy, up, uq, ur;
`ifdef MULDIV_UNSIGNED_EN
      sgn = !o[1];
`else
      sgn = 1'b1;
`endif
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      if (!o[0]) begin
         if (sgn) begin
            sq = sx * sy;
            return {1'b0, sq[63:0]};
         end
         up = ux * uy;
         return {1'b0, up};
      end
      if (y == '0) return {1'b1, 64'h0};
      if (sgn) begin
         sq = sx / sy;
         sr = sx % sy;
         return {1'b0, sr[31:0], sq[31:0]};
      end
      uq = ux / uy;
      ur = ux % uy;
      return {1'b0, ur[31:0], uq[31:0]};
   endfunction

   // Timeline model: t counts edges since acceptance; done at t==L.
   logic [W-1:0] e_hi = '0, e_lo = '0;
   logic         e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;
   bit           m_active = 1'b0;
   int           m_t = 0, m_L = 0;
   logic         m_dz = 1'b0;
   logic [63:0]  m_res = '0;

   always @(posedge clk or negedge reset) begin
      logic         can_acc;
      logic [2*W:0] r;
      if (!reset) begin
         e_hi = '0; e_lo = '0; e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0;
         m_active = 1'b0; m_t = 0;
      end else begin
         can_acc = !m_active || (m_t == m_L - 1);
         e_done = 1'b0;
         e_dz   = 1'b0;
         if (m_active) begin
            m_t++;
            if (m_t == m_L) begin
               e_done = 1'b1;
               e_dz   = m_dz;
               if (!m_dz) {e_hi, e_lo} = m_res;
               m_active = 1'b0;
            end
         end
         if (start && can_acc) begin
            r = model_res(op, a, b);
            m_dz = r[2*W];
            m_res = r[2*W-1:0];
            m_L = m_dz ? 2 : W + 2;
            m_t = 0;
            m_active = 1'b1;
         end
         e_busy = m_active && (m_dz ? (m_t == 1) : (m_t <= W + 1));
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         if ({busy, done, divby0, hi, lo} !== {e_busy, e_done, e_dz, e_hi, e_lo}) begin
            n_err++;
            $display("FAIL cycle@%0t: got busy=%b done=%b dz=%b hi=%h lo=%h, expected busy=%b done=%b dz=%b hi=%h lo=%h",
                     $time, busy, done, divby0, hi, lo, e_busy, e_done, e_dz, e_hi, e_lo);
         end
      end
   end

   task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Issue one operation, wait for done (bounded), check latency and results.
   task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] xhi, input logic [W-1:0] xlo, input bit xdz, input int repulse);
      int n;
      bit got;
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 60 && !got) begin
         @(negedge clk);
         n++;
         if (done) got = 1'b1;
         if (repulse > 0 && n == repulse) begin
            start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd0;
         end else begin
            start = 1'b0;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: no done within 60 cycles, required within %0d", nm, xdz ? 2 : W + 2);
      end else begin
         cmp({nm, " latency"}, 64'(n), xdz ? 64'd2 : 64'(W + 2));
         cmp({nm, " divby0"}, 64'(divby0), 64'(xdz));
         cmp({nm, " hi"}, 64'(hi), 64'(xhi));
         cmp({nm, " lo"}, 64'(lo), 64'(xlo));
         cmp({nm, " model"}, {e_hi, e_lo}, {xhi, xlo});
      end
      @(negedge clk);
   endtask

   initial begin
      bit seen_done;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      cmp("reset busy", 64'(busy), 64'd0);
      cmp("reset done", 64'(done), 64'd0);
      cmp("reset hilo", {hi, lo}, 64'd0);
      #2 reset = 1'b1;
      @(negedge clk);

      run_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
`ifdef MULDIV_UNSIGNED_EN
      run_op("multu ff*ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
      run_op("divu ff/2", 2'b11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'h7FFFFFFF, 1'b0, 0);
`else
      run_op("multu ff*ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 0);
      run_op("divu ff/2", 2'b11, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0);
`endif
      run_op("div -7/2", 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
      run_op("div min/-1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
      run_op("div 7/-5", 2'b01, 32'd7, 32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFF, 1'b0, 0);
      run_op("div 5/2", 2'b01, 32'd5, 32'd2, 32'h00000001, 32'h00000002, 1'b0, 0);
      run_op("div 5/0", 2'b01, 32'd5, 32'd0, 32'h00000001, 32'h00000002, 1'b1, 0);
      run_op("mult 2^16*2^16 repulse", 2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 5);

      // Reset during a division aborts it with no completion afterwards.
      op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      cmp("abort busy", 64'(busy), 64'd0);
      cmp("abort done", 64'(done), 64'd0);
      cmp("abort hilo", {hi, lo}, 64'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      cmp("abort no done", 64'(seen_done), 64'd0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
